trng_ctrl: RTL and testbench

- Sequencer for the 256-bit mod-P true random number generator.
- Gathers 16-bit entropy samples into a 256-bit candidate and applies rejection sampling against P, so accepted values are uniform in [0, P-1].
- Stores each accepted value as eight 32-bit words and serves word reads to the host with a ready/valid handshake.
- Sits between the raw entropy sampler and the 32-bit host read port.

---
 rtl/trng_ctrl.sv | 118 +++++++++++
 tb/tb_trng_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_ctrl.sv
// Sequencer for the 256-bit mod-P TRNG: packs 16-bit entropy samples into a candidate,
// rejection-samples it against P and serves accepted numbers as eight 32-bit words.
module trng_ctrl #(
    parameter logic [255:0] P       = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff,
    parameter int unsigned  MAX_REJ = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        samp_req,
    input  logic        samp_valid,
    input  logic [15:0] samp_data,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rdy,
    output logic        busy,
    output logic        err,
    output logic [7:0]  rej_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, READY} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0][15:0]  cand_q, cand_d;
    logic [7:0][31:0]   mem_q, mem_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;
    logic [7:0]         rej_cnt_q, rej_cnt_d;
    logic [7:0]         rej_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            mem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rej_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            rej_cnt_q  <= rej_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        mem_d      = mem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        rej_cnt_d  = rej_cnt_q;
        rej_inc    = (rej_cnt_q == 8'hFF) ? 8'hFF : rej_cnt_q + 8'd1;

        // Reads are decided on the pre-transition state, so a read issued
        // together with start still returns the old number.
        if (rd_en && state_q == READY) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[addr];
        end

        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    state_d   = COLLECT;
                    cnt_d     = '0;
                    rej_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            COLLECT: begin
                if (samp_valid) begin
                    cand_d[cnt_q] = samp_data;
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = CHECK;
                end
            end
            CHECK: begin
                if (cand_q < P) begin
                    mem_d   = cand_q;
                    state_d = READY;
                end else begin
                    rej_cnt_d = rej_inc;
                    if (rej_inc == 8'(MAX_REJ)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign samp_req = (state_q == COLLECT);
    assign busy     = (state_q == COLLECT) || (state_q == CHECK);
    assign rdy      = (state_q == READY);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign rej_cnt  = rej_cnt_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: instance 0 uses the default modulus, instance 1 uses P = 2^255, MAX_REJ = 3.
module tb_trng_ctrl;

    localparam logic [255:0] P0 = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    localparam logic [255:0] P1 = {1'b1, 255'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        start_r = '0, valid_r = '0, rd_en_r = '0;
    logic [1:0][15:0]  data_r  = '0;
    logic [1:0][2:0]   addr_r  = '0;
    logic [1:0]        samp_req_w, rd_valid_w, rdy_w, busy_w, err_w;
    logic [1:0][31:0]  rd_data_w;
    logic [1:0][7:0]   rej_cnt_w;

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] cur0;

    trng_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .samp_req(samp_req_w[0]),
        .samp_valid(valid_r[0]), .samp_data(data_r[0]), .rd_en(rd_en_r[0]), .addr(addr_r[0]),
        .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .rdy(rdy_w[0]), .busy(busy_w[0]),
        .err(err_w[0]), .rej_cnt(rej_cnt_w[0])
    );

    trng_ctrl #(.P(P1), .MAX_REJ(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .samp_req(samp_req_w[1]),
        .samp_valid(valid_r[1]), .samp_data(data_r[1]), .rd_en(rd_en_r[1]), .addr(addr_r[1]),
        .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .rdy(rdy_w[1]), .busy(busy_w[1]),
        .err(err_w[1]), .rej_cnt(rej_cnt_w[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int i);
        start_r[i] = 1'b1;
        tick();
        start_r[i] = 1'b0;
    endtask

    // Feeds samples k0..k1 of val; gap idle cycles (with junk data) precede each valid sample.
    task automatic feed(input int i, input int gap, input logic [255:0] val, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            for (int g = 0; g < gap; g++) begin
                valid_r[i] = 1'b0;
                data_r[i]  = 16'($urandom());
                tick();
            end
            valid_r[i] = 1'b1;
            data_r[i]  = val[16*k +: 16];
            tick();
        end
        valid_r[i] = 1'b0;
        data_r[i]  = 16'($urandom());
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({samp_req_w[i], rd_valid_w[i], rdy_w[i], busy_w[i], err_w[i]} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_flags[%0d] got %b exp 00000", i,
                         {samp_req_w[i], rd_valid_w[i], rdy_w[i], busy_w[i], err_w[i]});
            end
            n_cmp++;
            if (rd_data_w[i] !== 32'h0 || rej_cnt_w[i] !== 8'h0) begin
                n_bad++;
                $display("FAIL reset_data[%0d] got %h/%h exp 0/0", i, rd_data_w[i], rej_cnt_w[i]);
            end
        end
    endtask

    task automatic test_accept();
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'(k);
        do_start(0);
        feed(0, 0, v, 0, 15);
        n_cmp++;
        if (rdy_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_check_cycle got rdy=%b busy=%b exp rdy=0 busy=1", rdy_w[0], busy_w[0]);
        end
        tick();
        n_cmp++;
        if (rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rej_cnt_w[0] !== 8'd0) begin
            n_bad++;
            $display("FAIL accept_rdy_18 got rdy=%b busy=%b rej=%0d exp 1 0 0", rdy_w[0], busy_w[0], rej_cnt_w[0]);
        end
        rd_en_r[0] = 1'b1; addr_r[0] = 3'd0; tick();
        n_cmp++;
        if (rd_valid_w[0] !== 1'b1 || rd_data_w[0] !== 32'h00010000) begin
            n_bad++;
            $display("FAIL accept_addr0 got v=%b %h exp 1 00010000", rd_valid_w[0], rd_data_w[0]);
        end
        addr_r[0] = 3'd7; tick();
        rd_en_r[0] = 1'b0;
        n_cmp++;
        if (rd_valid_w[0] !== 1'b1 || rd_data_w[0] !== 32'h000F000E) begin
            n_bad++;
            $display("FAIL accept_addr7 got v=%b %h exp 1 000f000e", rd_valid_w[0], rd_data_w[0]);
        end
        cur0 = v;
    endtask

    task automatic test_read_handshake();
        for (int a = 0; a < 8; a++) begin
            rd_en_r[0] = 1'b1; addr_r[0] = 3'(a); tick();
            n_cmp++;
            if (rd_valid_w[0] !== 1'b1 || rd_data_w[0] !== cur0[32*a +: 32]) begin
                n_bad++;
                $display("FAIL b2b_read[%0d] got v=%b %h exp 1 %h", a, rd_valid_w[0], rd_data_w[0], cur0[32*a +: 32]);
            end
        end
        rd_en_r[0] = 1'b0; tick();
        n_cmp++;
        if (rd_valid_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_tail got rd_valid=%b exp 0", rd_valid_w[0]);
        end
    endtask

    task automatic test_boundary();
        logic [255:0] v;
        v = P0 - 256'd1;
        do_start(0);
        feed(0, 0, P0, 0, 15);
        tick();
        n_cmp++;
        if (samp_req_w[0] !== 1'b1 || rej_cnt_w[0] !== 8'd1 || err_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bound_eq_P got req=%b rej=%0d err=%b exp 1 1 0", samp_req_w[0], rej_cnt_w[0], err_w[0]);
        end
        feed(0, 0, v, 0, 15);
        tick();
        n_cmp++;
        if (rdy_w[0] !== 1'b1 || rej_cnt_w[0] !== 8'd1) begin
            n_bad++;
            $display("FAIL bound_P_minus1 got rdy=%b rej=%0d exp 1 1", rdy_w[0], rej_cnt_w[0]);
        end
        rd_en_r[0] = 1'b1; addr_r[0] = 3'd6; tick();
        rd_en_r[0] = 1'b0;
        n_cmp++;
        if (rd_data_w[0] !== 32'h00000001) begin
            n_bad++;
            $display("FAIL bound_word6 got %h exp 00000001", rd_data_w[0]);
        end
        cur0 = v;
    endtask

    task automatic test_gapped();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom();
        v[255] = 1'b0;
        do_start(0);
        feed(0, 2, v, 0, 7);
        // start and a read during COLLECT must both be ignored
        start_r[0] = 1'b1; rd_en_r[0] = 1'b1; addr_r[0] = 3'd3; tick();
        start_r[0] = 1'b0; rd_en_r[0] = 1'b0;
        n_cmp++;
        if (samp_req_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_start_ignored got req=%b busy=%b exp 1 1", samp_req_w[0], busy_w[0]);
        end
        tick();
        n_cmp++;
        if (rd_valid_w[0] !== 1'b0 || rd_data_w[0] !== 32'h00000001) begin
            n_bad++;
            $display("FAIL gap_read_not_rdy got v=%b %h exp 0 00000001", rd_valid_w[0], rd_data_w[0]);
        end
        feed(0, 2, v, 8, 15);
        tick();
        n_cmp++;
        if (rdy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_rdy got %b exp 1", rdy_w[0]);
        end
        for (int a = 0; a < 8; a++) begin
            rd_en_r[0] = 1'b1; addr_r[0] = 3'(a); tick();
            n_cmp++;
            if (rd_data_w[0] !== v[32*a +: 32]) begin
                n_bad++;
                $display("FAIL gap_word[%0d] got %h exp %h", a, rd_data_w[0], v[32*a +: 32]);
            end
        end
        rd_en_r[0] = 1'b0;
        cur0 = v;
    endtask

    task automatic test_reject();
        logic [255:0] bad, good;
        bad  = {16{16'hFFFF}};
        good = {16{16'h1234}};
        do_start(1);
        feed(1, 0, bad, 0, 15);
        tick();
        n_cmp++;
        if (samp_req_w[1] !== 1'b1 || rej_cnt_w[1] !== 8'd1 || rdy_w[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL rej_retry got req=%b rej=%0d rdy=%b exp 1 1 0", samp_req_w[1], rej_cnt_w[1], rdy_w[1]);
        end
        feed(1, 0, good, 0, 15);
        tick();
        n_cmp++;
        if (rdy_w[1] !== 1'b1 || rej_cnt_w[1] !== 8'd1) begin
            n_bad++;
            $display("FAIL rej_accept got rdy=%b rej=%0d exp 1 1", rdy_w[1], rej_cnt_w[1]);
        end
        for (int a = 0; a < 8; a++) begin
            rd_en_r[1] = 1'b1; addr_r[1] = 3'(a); tick();
            n_cmp++;
            if (rd_valid_w[1] !== 1'b1 || rd_data_w[1] !== 32'h12341234) begin
                n_bad++;
                $display("FAIL rej_word[%0d] got v=%b %h exp 1 12341234", a, rd_valid_w[1], rd_data_w[1]);
            end
        end
        rd_en_r[1] = 1'b0;
        tick();
    endtask

    task automatic test_health();
        logic [255:0] bad;
        bad = {16{16'hFFFF}};
        do_start(1);
        for (int r = 1; r <= 3; r++) begin
            feed(1, 0, bad, 0, 15);
            tick();
            n_cmp++;
            if (rej_cnt_w[1] !== 8'(r) || err_w[1] !== (r == 3) || samp_req_w[1] !== (r != 3)) begin
                n_bad++;
                $display("FAIL health_round[%0d] got rej=%0d err=%b req=%b exp %0d %b %b", r,
                         rej_cnt_w[1], err_w[1], samp_req_w[1], r, r == 3, r != 3);
            end
        end
        n_cmp++;
        if (rdy_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL health_idle got rdy=%b busy=%b exp 0 0", rdy_w[1], busy_w[1]);
        end
        tick();
        n_cmp++;
        if (err_w[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL health_sticky got %b exp 1", err_w[1]);
        end
        do_start(1);
        n_cmp++;
        if (err_w[1] !== 1'b0 || samp_req_w[1] !== 1'b1 || rej_cnt_w[1] !== 8'd0) begin
            n_bad++;
            $display("FAIL health_clear got err=%b req=%b rej=%0d exp 0 1 0", err_w[1], samp_req_w[1], rej_cnt_w[1]);
        end
        feed(1, 0, 256'h0, 0, 15);
        tick();
    endtask

    // Random candidates against P = 2^255: the model only tracks accept/reject and the rejection count.
    task automatic test_random();
        logic [255:0] v;
        int rej, a;
        for (int n = 0; n < 10; n++) begin
            do_start(1);
            rej = 0;
            for (int t = 0; t < 3; t++) begin
                for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom();
                feed(1, $urandom_range(0, 2), v, 0, 15);
                n_cmp++;
                if (busy_w[1] !== 1'b1 || samp_req_w[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rnd_check[%0d] got busy=%b req=%b exp 1 0", n, busy_w[1], samp_req_w[1]);
                end
                tick();
                if (v < P1) begin
                    a = $urandom_range(0, 7);
                    rd_en_r[1] = 1'b1; addr_r[1] = 3'(a); tick(); rd_en_r[1] = 1'b0;
                    n_cmp++;
                    if (rdy_w[1] !== 1'b1 || rej_cnt_w[1] !== 8'(rej) || rd_data_w[1] !== v[32*a +: 32]) begin
                        n_bad++;
                        $display("FAIL rnd_accept[%0d] got rdy=%b rej=%0d %h exp 1 %0d %h", n,
                                 rdy_w[1], rej_cnt_w[1], rd_data_w[1], rej, v[32*a +: 32]);
                    end
                    break;
                end
                rej++;
                n_cmp++;
                if (rej_cnt_w[1] !== 8'(rej) || err_w[1] !== (rej == 3) || samp_req_w[1] !== (rej != 3)) begin
                    n_bad++;
                    $display("FAIL rnd_reject[%0d] got rej=%0d err=%b req=%b exp %0d %b %b", n,
                             rej_cnt_w[1], err_w[1], samp_req_w[1], rej, rej == 3, rej != 3);
                end
            end
        end
    endtask

    task automatic test_restart();
        logic [255:0] v2;
        for (int w = 0; w < 8; w++) v2[32*w +: 32] = $urandom();
        v2[255] = 1'b0;
        start_r[0] = 1'b1; rd_en_r[0] = 1'b1; addr_r[0] = 3'd5; tick();
        start_r[0] = 1'b0; rd_en_r[0] = 1'b0;
        n_cmp++;
        if (rd_valid_w[0] !== 1'b1 || rd_data_w[0] !== cur0[32*5 +: 32] || rdy_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_read got v=%b %h rdy=%b busy=%b exp 1 %h 0 1", rd_valid_w[0],
                     rd_data_w[0], rdy_w[0], busy_w[0], cur0[32*5 +: 32]);
        end
        feed(0, 0, {8{32'hDEADBEEF}}, 0, 4);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({samp_req_w[0], rd_valid_w[0], rdy_w[0], busy_w[0], err_w[0]} !== 5'b0 ||
            rd_data_w[0] !== 32'h0 || rej_cnt_w[0] !== 8'h0) begin
            n_bad++;
            $display("FAIL restart_async_rst got flags=%b %h %h exp 00000 0 0",
                     {samp_req_w[0], rd_valid_w[0], rdy_w[0], busy_w[0], err_w[0]}, rd_data_w[0], rej_cnt_w[0]);
        end
        tick();
        rst = 1'b0;
        tick();
        do_start(0);
        feed(0, 0, v2, 0, 14);
        n_cmp++;
        if (samp_req_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_15_samples got req=%b exp 1", samp_req_w[0]);
        end
        feed(0, 0, v2, 15, 15);
        tick();
        n_cmp++;
        if (rdy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_rdy got %b exp 1", rdy_w[0]);
        end
        for (int a = 0; a < 8; a += 4) begin
            rd_en_r[0] = 1'b1; addr_r[0] = 3'(a); tick();
            n_cmp++;
            if (rd_data_w[0] !== v2[32*a +: 32]) begin
                n_bad++;
                $display("FAIL restart_word[%0d] got %h exp %h", a, rd_data_w[0], v2[32*a +: 32]);
            end
        end
        rd_en_r[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_accept();
        test_read_handshake();
        test_boundary();
        test_gapped();
        test_reject();
        test_health();
        test_random();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
